pwm_note_sequencer: RTL and testbench
=====================================

// Module: pwm_note_sequencer
// PURPOSE
//  Plays a programmable melody on the PWM sine generator. Holds a small note table; each entry is (divider, duration).
//  Steps through the table on a millisecond-scale tick and drives the generator's divider input plus a gate for the output pin.
//  Sits between the top level and pwm_sine; the top ANDs gate with pwm.
// PARAMETERS
//  CLOCK_FREQ  40_000_000  system clock frequency, Hz
//  TICK_HZ     1000        duration tick rate; TICK_DIV = CLOCK_FREQ/TICK_HZ cycles per tick (must be >= 2)
//  NUM_NOTES   16          table depth, power of two; IDX_W = log2(NUM_NOTES)
//  DIV_W       12          divider width, matches pwm_sine divider input
//  DUR_W       8           duration field width, in ticks
//  GAP_TICKS   1           silent ticks between notes; 0 = legato
// PORTS
//  clk        in   1            system clock
//  rst_n      in   1            async active-low reset
//  start      in   1            pulse; start or restart playback at entry 0
//  stop       in   1            pulse; abort playback
//  loop_en    in   1            1 = wrap to entry 0 at end of sequence
//  cfg_we     in   1            table write strobe
//  cfg_addr   in   IDX_W        table write address
//  cfg_data   in   DIV_W+DUR_W  {divider, duration}
//  divider    out  DIV_W        to pwm_sine divider
//  gate       out  1            1 = tone audible
//  playing    out  1            1 in LOAD/PLAY/GAP
//  note_idx   out  IDX_W        current table index
//  done       out  1            1-cycle pulse on entry to DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; divider=0, gate=0, playing=0, note_idx=0, done=0; prescaler=0. Table contents undefined.
//  States: IDLE, LOAD, PLAY, GAP, DONE. All outputs registered.
//  stop has priority over start in the same cycle: any state -> IDLE next cycle; gate=0, divider=0, note_idx=0.
//  start (no stop), any state -> LOAD with note_idx=0. Restart mid-note is allowed.
//  LOAD (1 cycle): reads entry[note_idx].
//   - dur==0 is the end marker.
//     - note_idx==0 -> DONE (empty sequence).
//     - loop_en=1 -> note_idx=0, stay LOAD.
//     - loop_en=0 -> DONE.
//   - otherwise -> PLAY: divider=entry.div, gate=(entry.div!=0), dur_cnt=dur, prescaler cleared.
//   - entry.div==0 is a rest: gate=0, timing unchanged.
//  PLAY: prescaler counts 0..TICK_DIV-1; tick when it reaches TICK_DIV-1; dur_cnt decrements on tick.
//   - On the tick where dur_cnt==1: if GAP_TICKS>0, go to GAP (gate=0, gap_cnt=GAP_TICKS, prescaler cleared).
//     Otherwise advance the index and go to LOAD.
//   - A note therefore spends exactly dur*TICK_DIV cycles in PLAY.
//  GAP: gate=0, divider held; same tick counting; after GAP_TICKS ticks, advance the index and go to LOAD.
//  Advance: if note_idx==NUM_NOTES-1, go to note_idx=0 when loop_en=1, else DONE. Otherwise note_idx+1.
//   - loop_en is sampled at the advance or marker decision, not latched at start.
//  Gate and divider are unchanged during LOAD. With GAP_TICKS=0 the tone stays continuous across notes.
//  DONE: done=1 for the entry cycle only; gate=0, divider=0, playing=0; wait for start.
//  Table: cfg writes accepted in any state.
//   - Read is synchronous; a write to the address being read in LOAD in the same cycle returns the old value.
//   - Edits affect an entry the next time it is loaded.
// STRUCTURE
//  Package pwm_seq_pkg holds:
//   - state enum (IDLE/LOAD/PLAY/GAP/DONE)
//   - DIV_W/DUR_W defaults
//   - entry field slice localparams
//  Sub-module pwm_tick_gen: prescaler with clear input and tick output, parameter TICK_DIV.
//  Note table is an inline register array.
// TESTING (CLOCK_FREQ=100, TICK_HZ=10 -> TICK_DIV=10, GAP_TICKS=1, NUM_NOTES=4)
//  1. Reset mid-PLAY -> all outputs 0 in the same cycle, state IDLE; no done pulse.
//  2. Table {(0x100,2),(0x080,1),(x,0)}, start, loop_en=0:
//     - divider=0x100, gate=1 for 20 cycles; gate=0 for 10; 1 LOAD cycle
//     - divider=0x080 for 10 cycles; gate=0 for 10
//     - LOAD, marker -> done pulse; playing=0.
//  3. Same table with loop_en=1 -> after entry 1 the sequence returns to note_idx=0, divider=0x100; no done pulse.
//  4. All 4 entries nonzero, loop_en=0 -> after index 3 -> DONE. With loop_en=1 -> wraps to 0.
//  5. Entry (0x000,3) -> gate=0 for 30 PLAY cycles, then the next note is audible.
//  6. Simultaneous events:
//     - start+stop same cycle during PLAY -> IDLE.
//     - start alone during GAP -> LOAD at index 0.
//     - cfg write to entry 0 during its LOAD cycle -> old value plays; new value plays on the next loop.

Source files
------------

// File: rtl/pwm_note_sequencer_pkg.sv
// Shared types and constants for the PWM note sequencer.
package pwm_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Default field widths; the divider width matches the pwm_sine divider input
  localparam int DEF_DIV_W = 12;
  localparam int DEF_DUR_W = 8;

  // Table entry layout is {divider, duration}: duration sits in the low bits
  // and the divider starts directly above it.
  localparam int ENTRY_DUR_LSB = 0;

endpackage

// File: rtl/pwm_note_sequencer_if.sv
// Control/config/status bundle between the host side and the note sequencer.
interface pwm_note_sequencer_if #(
  parameter int IDX_W = 4,
  parameter int DIV_W = pwm_seq_pkg::DEF_DIV_W,
  parameter int DUR_W = pwm_seq_pkg::DEF_DUR_W
);
  logic                   start;
  logic                   stop;
  logic                   loop_en;
  logic                   cfg_we;
  logic [IDX_W-1:0]       cfg_addr;
  logic [DIV_W+DUR_W-1:0] cfg_data;
  logic [DIV_W-1:0]       divider;
  logic                   gate;
  logic                   playing;
  logic [IDX_W-1:0]       note_idx;
  logic                   done;

  modport master (
    output start, stop, loop_en, cfg_we, cfg_addr, cfg_data,
    input  divider, gate, playing, note_idx, done
  );

  modport slave (
    input  start, stop, loop_en, cfg_we, cfg_addr, cfg_data,
    output divider, gate, playing, note_idx, done
  );
endinterface

// File: rtl/pwm_note_sequencer_tick_gen.sv
// Duration prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
module pwm_tick_gen #(
  parameter int TICK_DIV = 40_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CNT_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Free-running prescaler, restarted by clr_i and on every tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/pwm_note_sequencer.sv
// Melody sequencer: steps a {divider, duration} table on a slow tick and
// drives the pwm_sine divider plus an output gate.
//
//  state | meaning
//  IDLE  | stopped, outputs silent, waiting for start
//  LOAD  | one cycle: fetch entry[note_idx], decide marker/play
//  PLAY  | tone held for dur ticks
//  GAP   | silent ticks between notes, divider held
//  DONE  | sequence finished, done pulsed on entry, waiting for start
module pwm_note_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int CLOCK_FREQ = 40_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int NUM_NOTES  = 16,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int DUR_W      = DEF_DUR_W,
  parameter int GAP_TICKS  = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  pwm_note_sequencer_if.slave bus
);
  localparam int TICK_DIV = CLOCK_FREQ / TICK_HZ;
  localparam int IDX_W    = (NUM_NOTES < 2) ? 1 : $clog2(NUM_NOTES);
  localparam int ENT_W    = DIV_W + DUR_W;
  localparam int DIV_LSB  = ENTRY_DUR_LSB + DUR_W;
  localparam int GAP_W    = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

  logic [ENT_W-1:0] table_q [NUM_NOTES];

  state_e           state_q;
  logic [IDX_W-1:0] note_idx_q;
  logic [DIV_W-1:0] divider_q;
  logic             gate_q;
  logic             playing_q;
  logic             done_q;
  logic [DUR_W-1:0] dur_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;

  logic             tick;
  logic             tick_clr;
  logic [ENT_W-1:0] entry;
  logic [DIV_W-1:0] entry_div;
  logic [DUR_W-1:0] entry_dur;
  logic             adv_end;
  logic [IDX_W-1:0] adv_idx_d;

  // Prescaler only runs while a note or gap is being timed, so every
  // PLAY/GAP period starts from a fresh count.
  assign tick_clr = !((state_q == PLAY) || (state_q == GAP));

  pwm_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  // Note table: writable at any time, no reset (contents undefined after reset)
  always_ff @(posedge clk) begin
    if (bus.cfg_we) begin
      table_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // The table is registered, so the entry LOAD sees is the value held
  // before a same-cycle write lands.
  assign entry     = table_q[note_idx_q];
  assign entry_dur = entry[ENTRY_DUR_LSB +: DUR_W];
  assign entry_div = entry[DIV_LSB +: DIV_W];

  // End-of-note advance target; loop_en is sampled at the decision point
  always_comb begin
    adv_end   = (note_idx_q == LAST_IDX) && !bus.loop_en;
    adv_idx_d = (note_idx_q == LAST_IDX) ? '0 : note_idx_q + 1'b1;
  end

  // Sequencer FSM with registered outputs; stop beats start, start beats all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      note_idx_q <= '0;
      divider_q  <= '0;
      gate_q     <= 1'b0;
      playing_q  <= 1'b0;
      done_q     <= 1'b0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state_q    <= IDLE;
        gate_q     <= 1'b0;
        divider_q  <= '0;
        note_idx_q <= '0;
        playing_q  <= 1'b0;
      end else if (bus.start) begin
        state_q    <= LOAD;
        note_idx_q <= '0;
        playing_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE, DONE: begin
          end
          LOAD: begin
            if (entry_dur == '0) begin
              if ((note_idx_q != '0) && bus.loop_en) begin
                note_idx_q <= '0;
              end else begin
                state_q   <= DONE;
                done_q    <= 1'b1;
                gate_q    <= 1'b0;
                divider_q <= '0;
                playing_q <= 1'b0;
              end
            end else begin
              state_q   <= PLAY;
              divider_q <= entry_div;
              gate_q    <= (entry_div != '0);
              dur_cnt_q <= entry_dur;
            end
          end
          PLAY: begin
            if (tick) begin
              if (dur_cnt_q == DUR_W'(1)) begin
                if (GAP_TICKS > 0) begin
                  state_q   <= GAP;
                  gate_q    <= 1'b0;
                  gap_cnt_q <= GAP_W'(GAP_TICKS);
                end else if (adv_end) begin
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  gate_q    <= 1'b0;
                  divider_q <= '0;
                  playing_q <= 1'b0;
                end else begin
                  state_q    <= LOAD;
                  note_idx_q <= adv_idx_d;
                end
              end else begin
                dur_cnt_q <= dur_cnt_q - 1'b1;
              end
            end
          end
          GAP: begin
            if (tick) begin
              if (gap_cnt_q == GAP_W'(1)) begin
                if (adv_end) begin
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  gate_q    <= 1'b0;
                  divider_q <= '0;
                  playing_q <= 1'b0;
                end else begin
                  state_q    <= LOAD;
                  note_idx_q <= adv_idx_d;
                end
              end else begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.divider  = divider_q;
  assign bus.gate     = gate_q;
  assign bus.playing  = playing_q;
  assign bus.note_idx = note_idx_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_pwm_note_sequencer.sv
// Scoreboard bench for pwm_note_sequencer: per-cycle expected outputs are
// queued when a scenario is launched and popped one per clock.
module tb_pwm_note_sequencer;
  localparam int CLOCK_FREQ = 100;
  localparam int TICK_HZ    = 10;
  localparam int NUM_NOTES  = 4;
  localparam int DIV_W      = 12;
  localparam int DUR_W      = 8;
  localparam int GAP_TICKS  = 1;
  localparam int IDX_W      = 2;

  typedef logic [DIV_W+IDX_W+2:0] obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pwm_note_sequencer_if #(.IDX_W(IDX_W), .DIV_W(DIV_W), .DUR_W(DUR_W)) bus ();

  pwm_note_sequencer #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .TICK_HZ   (TICK_HZ),
    .NUM_NOTES (NUM_NOTES),
    .DIV_W     (DIV_W),
    .DUR_W     (DUR_W),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  obs_t  exp_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;
  int    step_no = 0;
  string scen = "init";

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // {divider, gate, playing, note_idx, done}
  function automatic obs_t observe();
    return {bus.divider, bus.gate, bus.playing, bus.note_idx, bus.done};
  endfunction

  task automatic push(input int d, input int g, input int p, input int i, input int dn, input int n);
    repeat (n) exp_q.push_back({12'(d), 1'(g), 1'(p), 2'(i), 1'(dn)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      step_no++;
      chk($sformatf("%s#%0d", scen, step_no), 32'(observe()), 32'(e));
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      step();
      guard++;
    end
    if (exp_q.size() != 0) chk({scen, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic begin_scen(input string name);
    scen = name;
    step_no = 0;
  endtask

  task automatic wr(input int a, input int d, input int dur);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 2'(a);
    bus.cfg_data = {12'(d), 8'(dur)};
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_stop();
    push(0, 0, 0, 0, 0, 2);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end want end");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.loop_en  = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_init", 32'(observe()), 32'd0);
    rst_n = 1'b1;

    // 1: async reset in the middle of a note
    wr(0, 'h100, 2);
    wr(1, 'h080, 1);
    wr(2, 'h000, 0);
    begin_scen("rst_play");
    push(0, 0, 1, 0, 0, 1);
    push('h100, 1, 1, 0, 0, 5);
    pulse_start();
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(observe()), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold", 32'(observe()), 32'd0);
    end
    rst_n = 1'b1;
    wr(0, 'h100, 2);
    wr(1, 'h080, 1);
    wr(2, 'h000, 0);

    // 2: three-entry table, no loop
    begin_scen("seq");
    bus.loop_en = 1'b0;
    push(0, 0, 1, 0, 0, 1);
    push('h100, 1, 1, 0, 0, 20);
    push('h100, 0, 1, 0, 0, 10);
    push('h100, 0, 1, 1, 0, 1);
    push('h080, 1, 1, 1, 0, 10);
    push('h080, 0, 1, 1, 0, 10);
    push('h080, 0, 1, 2, 0, 1);
    push(0, 0, 0, 2, 1, 1);
    push(0, 0, 0, 2, 0, 2);
    pulse_start();
    drain();

    // 3: same table with looping
    begin_scen("loop");
    bus.loop_en = 1'b1;
    push(0, 0, 1, 0, 0, 1);
    push('h100, 1, 1, 0, 0, 20);
    push('h100, 0, 1, 0, 0, 10);
    push('h100, 0, 1, 1, 0, 1);
    push('h080, 1, 1, 1, 0, 10);
    push('h080, 0, 1, 1, 0, 10);
    push('h080, 0, 1, 2, 0, 1);
    push('h080, 0, 1, 0, 0, 1);
    push('h100, 1, 1, 0, 0, 20);
    push('h100, 0, 1, 0, 0, 3);
    pulse_start();
    drain();
    do_stop();

    // 4: full table, end-of-table advance
    for (int i = 0; i < 4; i++) wr(i, (i + 1) * 16, 1);
    for (int pass = 0; pass < 2; pass++) begin
      begin_scen(pass == 0 ? "full" : "full_loop");
      bus.loop_en = (pass == 1);
      push(0, 0, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
        push((i + 1) * 16, 1, 1, i, 0, 10);
        push((i + 1) * 16, 0, 1, i, 0, 10);
        if (i < 3) push((i + 1) * 16, 0, 1, i + 1, 0, 1);
      end
      if (pass == 0) begin
        push(0, 0, 0, 3, 1, 1);
        push(0, 0, 0, 3, 0, 1);
      end else begin
        push('h040, 0, 1, 0, 0, 1);
        push('h010, 1, 1, 0, 0, 10);
        push('h010, 0, 1, 0, 0, 2);
      end
      pulse_start();
      drain();
    end
    do_stop();

    // 5: rest entry, then audible note
    begin_scen("rest");
    bus.loop_en = 1'b0;
    wr(0, 'h000, 3);
    wr(1, 'h050, 1);
    wr(2, 'h000, 0);
    push(0, 0, 1, 0, 0, 31);
    push(0, 0, 1, 0, 0, 10);
    push(0, 0, 1, 1, 0, 1);
    push('h050, 1, 1, 1, 0, 10);
    push('h050, 0, 1, 1, 0, 10);
    push('h050, 0, 1, 2, 0, 1);
    push(0, 0, 0, 2, 1, 1);
    pulse_start();
    drain();

    // Empty sequence: marker at entry 0 ends even with looping enabled
    begin_scen("empty");
    bus.loop_en = 1'b1;
    wr(0, 'h123, 0);
    push(0, 0, 1, 0, 0, 1);
    push(0, 0, 0, 0, 1, 1);
    push(0, 0, 0, 0, 0, 1);
    pulse_start();
    drain();

    // 6a: start and stop together during PLAY
    begin_scen("startstop");
    wr(0, 'h100, 1);
    wr(1, 'h000, 0);
    push(0, 0, 1, 0, 0, 1);
    push('h100, 1, 1, 0, 0, 4);
    pulse_start();
    drain();
    push(0, 0, 0, 0, 0, 2);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    drain();

    // 6b: restart during GAP, then 6c: write entry 0 during its LOAD
    begin_scen("restart_gap");
    push(0, 0, 1, 0, 0, 1);
    push('h100, 1, 1, 0, 0, 10);
    push('h100, 0, 1, 0, 0, 3);
    pulse_start();
    drain();
    push('h100, 0, 1, 0, 0, 1);
    push('h100, 1, 1, 0, 0, 10);
    push('h100, 0, 1, 0, 0, 10);
    push('h100, 0, 1, 1, 0, 1);
    push('h100, 0, 1, 0, 0, 1);
    pulse_start();
    drain();
    begin_scen("cfg_in_load");
    push('h100, 1, 1, 0, 0, 10);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 2'd0;
    bus.cfg_data = {12'h200, 8'd1};
    step();
    bus.cfg_we = 1'b0;
    push('h100, 0, 1, 0, 0, 10);
    push('h100, 0, 1, 1, 0, 1);
    push('h100, 0, 1, 0, 0, 1);
    push('h200, 1, 1, 0, 0, 10);
    drain();
    do_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
